// File: rtl/sr_bank_en_if.sv
// sr_bank_en_if: control and status bundle for the clocked set/reset bank.
interface sr_bank_en_if #(parameter int N = 4);
  logic [N-1:0] s;
  logic [N-1:0] r;
  logic [N-1:0] en;
  logic [1:0]   mode;
  logic         clr;
  logic [N-1:0] q;
  logic [N-1:0] qbar;
  logic [N-1:0] conflict;
  logic [N-1:0] change;
  logic [7:0]   chg_cnt;
  modport master (output s, r, en, mode, clr, input q, qbar, conflict, change, chg_cnt);
  modport slave (input s, r, en, mode, clr, output q, qbar, conflict, change, chg_cnt);
endinterface

// File: rtl/sr_bank_en.sv
// sr_bank_en: clocked SR bank with per-channel enable, selectable S=R=1 policy and change tracking.
module sr_bank_en #(
  parameter int N = 4,
  parameter logic [N-1:0] INIT = '0
) (
  input logic clk,
  input logic rst_n,
  sr_bank_en_if.slave bus
);
  logic [N-1:0] q_r, conflict_r, change_r, cf, q_cf, q_sr, q_nx;
  logic [7:0] cnt_r;
  always_comb begin
    cf = bus.en & bus.s & bus.r;
    q_cf = bus.mode == 2'b00 ? q_r : bus.mode == 2'b01 ? '1 : bus.mode == 2'b10 ? '0 : ~q_r;
    q_sr = (q_r | (bus.en & bus.s & ~bus.r)) & ~(bus.en & bus.r & ~bus.s);
    q_nx = (q_sr & ~cf) | (q_cf & cf);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r <= INIT;
      conflict_r <= '0;
      change_r <= '0;
      cnt_r <= '0;
    end else begin
      q_r <= q_nx;
      change_r <= q_nx ^ q_r;
      // a new conflict outranks a simultaneous clear
      conflict_r <= cf | (bus.clr ? '0 : conflict_r);
      cnt_r <= bus.clr ? 8'd0 : (|(q_nx ^ q_r) && cnt_r != 8'd255) ? cnt_r + 8'd1 : cnt_r;
    end
  end
  assign bus.q = q_r;
  assign bus.qbar = ~q_r;
  assign bus.conflict = conflict_r;
  assign bus.change = change_r;
  assign bus.chg_cnt = cnt_r;
endmodule

// File: tb/tb_sr_bank_en.sv
// tb_sr_bank_en: directed self-checking bench for sr_bank_en with N=4, INIT=1010.
module tb_sr_bank_en;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;
  sr_bank_en_if #(.N(4)) bus ();
  sr_bank_en #(.N(4), .INIT(4'b1010)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] en, input logic [3:0] s, input logic [3:0] r, input logic [1:0] mode, input logic clr);
    bus.en = en;
    bus.s = s;
    bus.r = r;
    bus.mode = mode;
    bus.clr = clr;
  endtask

  task automatic test_reset();
    drive(4'b1111, 4'b0101, 4'b0000, 2'b00, 1'b0);
    tick();
    total++; if (bus.q !== 4'b1111) begin bad++; $display("FAIL pre_reset_q got=%b exp=%b", bus.q, 4'b1111); end
    total++; if (bus.chg_cnt !== 8'd1) begin bad++; $display("FAIL pre_reset_cnt got=%0d exp=1", bus.chg_cnt); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (bus.q !== 4'b1010) begin bad++; $display("FAIL reset_q got=%b exp=1010", bus.q); end
    total++; if (bus.qbar !== 4'b0101) begin bad++; $display("FAIL reset_qbar got=%b exp=0101", bus.qbar); end
    total++; if (bus.conflict !== 4'b0000) begin bad++; $display("FAIL reset_conflict got=%b exp=0000", bus.conflict); end
    total++; if (bus.change !== 4'b0000) begin bad++; $display("FAIL reset_change got=%b exp=0000", bus.change); end
    total++; if (bus.chg_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", bus.chg_cnt); end
    tick();
    rst_n = 1'b1;
    drive(4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0);
    tick();
    total++; if (bus.q !== 4'b1010) begin bad++; $display("FAIL reset_hold_q got=%b exp=1010", bus.q); end
  endtask

  task automatic test_basic();
    drive(4'b1111, 4'b0000, 4'b1111, 2'b00, 1'b1);
    tick();
    total++; if (bus.q !== 4'b0000) begin bad++; $display("FAIL basic_clear_q got=%b exp=0000", bus.q); end
    total++; if (bus.chg_cnt !== 8'd0) begin bad++; $display("FAIL basic_clear_cnt got=%0d exp=0", bus.chg_cnt); end
    drive(4'b1111, 4'b0011, 4'b1100, 2'b00, 1'b0);
    tick();
    total++; if (bus.q !== 4'b0011) begin bad++; $display("FAIL basic_q got=%b exp=0011", bus.q); end
    total++; if (bus.qbar !== 4'b1100) begin bad++; $display("FAIL basic_qbar got=%b exp=1100", bus.qbar); end
    total++; if (bus.change !== 4'b0011) begin bad++; $display("FAIL basic_change got=%b exp=0011", bus.change); end
    total++; if (bus.chg_cnt !== 8'd1) begin bad++; $display("FAIL basic_cnt got=%0d exp=1", bus.chg_cnt); end
    tick();
    total++; if (bus.q !== 4'b0011) begin bad++; $display("FAIL basic_again_q got=%b exp=0011", bus.q); end
    total++; if (bus.change !== 4'b0000) begin bad++; $display("FAIL basic_again_change got=%b exp=0000", bus.change); end
    total++; if (bus.chg_cnt !== 8'd1) begin bad++; $display("FAIL basic_again_cnt got=%0d exp=1", bus.chg_cnt); end
  endtask

  task automatic test_enable();
    drive(4'b1111, 4'b0000, 4'b1111, 2'b00, 1'b0);
    tick();
    drive(4'b0001, 4'b1111, 4'b0000, 2'b00, 1'b0);
    tick();
    total++; if (bus.q !== 4'b0001) begin bad++; $display("FAIL enable_set_q got=%b exp=0001", bus.q); end
    drive(4'b0000, 4'b0000, 4'b1111, 2'b00, 1'b0);
    tick();
    total++; if (bus.q !== 4'b0001) begin bad++; $display("FAIL enable_hold_q got=%b exp=0001", bus.q); end
    total++; if (bus.change !== 4'b0000) begin bad++; $display("FAIL enable_hold_change got=%b exp=0000", bus.change); end
  endtask

  task automatic test_conflict();
    logic [3:0] tog [3] = '{4'b0001, 4'b0000, 4'b0001};
    drive(4'b1111, 4'b0000, 4'b1111, 2'b00, 1'b1);
    tick();
    drive(4'b0001, 4'b0001, 4'b0001, 2'b00, 1'b0);
    tick();
    total++; if (bus.q !== 4'b0000) begin bad++; $display("FAIL mode00_q got=%b exp=0000", bus.q); end
    total++; if (bus.conflict !== 4'b0001) begin bad++; $display("FAIL mode00_conflict got=%b exp=0001", bus.conflict); end
    bus.mode = 2'b01;
    tick();
    total++; if (bus.q !== 4'b0001) begin bad++; $display("FAIL mode01_q got=%b exp=0001", bus.q); end
    bus.mode = 2'b10;
    tick();
    total++; if (bus.q !== 4'b0000) begin bad++; $display("FAIL mode10_q got=%b exp=0000", bus.q); end
    bus.mode = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (bus.q !== tog[i]) begin bad++; $display("FAIL mode11_q[%0d] got=%b exp=%b", i, bus.q, tog[i]); end
      total++; if (bus.conflict !== 4'b0001) begin bad++; $display("FAIL mode11_conflict[%0d] got=%b exp=0001", i, bus.conflict); end
    end
    drive(4'b0001, 4'b0001, 4'b0001, 2'b00, 1'b1);
    tick();
    total++; if (bus.conflict !== 4'b0001) begin bad++; $display("FAIL clr_vs_conflict got=%b exp=0001", bus.conflict); end
    drive(4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b1);
    tick();
    total++; if (bus.conflict !== 4'b0000) begin bad++; $display("FAIL clr_conflict got=%b exp=0000", bus.conflict); end
  endtask

  task automatic test_saturation();
    drive(4'b1111, 4'b1111, 4'b1111, 2'b11, 1'b1);
    tick();
    total++; if (bus.chg_cnt !== 8'd0) begin bad++; $display("FAIL sat_start_cnt got=%0d exp=0", bus.chg_cnt); end
    bus.clr = 1'b0;
    repeat (300) tick();
    total++; if (bus.chg_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt got=%0d exp=255", bus.chg_cnt); end
    total++; if (bus.change !== 4'b1111) begin bad++; $display("FAIL sat_change got=%b exp=1111", bus.change); end
    bus.clr = 1'b1;
    tick();
    total++; if (bus.chg_cnt !== 8'd0) begin bad++; $display("FAIL sat_clr_cnt got=%0d exp=0", bus.chg_cnt); end
    bus.clr = 1'b0;
    tick();
    total++; if (bus.chg_cnt !== 8'd1) begin bad++; $display("FAIL sat_restart_cnt got=%0d exp=1", bus.chg_cnt); end
  endtask

  task automatic test_reset_toggle();
    repeat (3) tick();
    total++; if (bus.chg_cnt !== 8'd4) begin bad++; $display("FAIL rt_pre_cnt got=%0d exp=4", bus.chg_cnt); end
    #3 rst_n = 1'b0;
    #1;
    total++; if (bus.q !== 4'b1010) begin bad++; $display("FAIL rt_q got=%b exp=1010", bus.q); end
    total++; if (bus.change !== 4'b0000) begin bad++; $display("FAIL rt_change got=%b exp=0000", bus.change); end
    total++; if (bus.chg_cnt !== 8'd0) begin bad++; $display("FAIL rt_cnt got=%0d exp=0", bus.chg_cnt); end
    total++; if (bus.conflict !== 4'b0000) begin bad++; $display("FAIL rt_conflict got=%b exp=0000", bus.conflict); end
    tick();
    rst_n = 1'b1;
    tick();
    total++; if (bus.q !== 4'b0101) begin bad++; $display("FAIL rt_after_q got=%b exp=0101", bus.q); end
    total++; if (bus.chg_cnt !== 8'd1) begin bad++; $display("FAIL rt_after_cnt got=%0d exp=1", bus.chg_cnt); end
    total++; if (bus.conflict !== 4'b1111) begin bad++; $display("FAIL rt_after_conflict got=%b exp=1111", bus.conflict); end
  endtask

  initial begin
    drive(4'b0000, 4'b0000, 4'b0000, 2'b00, 1'b0);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    test_reset();
    test_basic();
    test_enable();
    test_conflict();
    test_saturation();
    test_reset_toggle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
